// File: rtl/handshake_constant_pkg.sv
// Shared types and helpers for the registered handshake constant producers.
package handshake_constant_pkg;

    localparam int unsigned MAX_REPEAT = 65535;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned rep);
        return $clog2(rep + 1);
    endfunction

endpackage

// File: rtl/handshake_constant_out_reg.sv
// One-slot registered handshake output stage (data, valid, optional last).
// The last flag exists only when HANDSHAKE_CONSTANT_LAST_EN is defined.
module handshake_constant_out_reg #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] data,
`ifdef HANDSHAKE_CONSTANT_LAST_EN
    input  logic                  last,
    output logic                  outs_last,
`endif
    output logic                  load_en,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid
);

    // Slot is free when empty or being drained in this same cycle.
    assign load_en = !outs_valid || drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            outs_valid <= 1'b0;
            outs       <= '0;
`ifdef HANDSHAKE_CONSTANT_LAST_EN
            outs_last  <= 1'b0;
`endif
        end else if (load && load_en) begin
            outs_valid <= 1'b1;
            outs       <= data;
`ifdef HANDSHAKE_CONSTANT_LAST_EN
            outs_last  <= last;
`endif
        end else if (drain) begin
            outs_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_constant_repeat.sv
// Registered burst generator: each ctrl token yields REPEAT tokens VALUE + k*STEP.
// Optional outs_last port enabled by HANDSHAKE_CONSTANT_LAST_EN.
module handshake_constant_repeat
    import handshake_constant_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] VALUE      = 32'hFFFFFFFD,
    parameter int unsigned REPEAT     = 1,
    parameter logic [31:0] STEP       = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
`ifdef HANDSHAKE_CONSTANT_LAST_EN
    output logic                  outs_last,
`endif
    input  logic                  outs_ready
);

    localparam int unsigned           CNT_W = cnt_width(REPEAT);
    localparam logic [DATA_WIDTH-1:0] VAL   = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] STP   = DATA_WIDTH'(STEP);

    generate
        if (REPEAT == 0 || REPEAT > MAX_REPEAT) begin : g_bad_repeat
            $error("handshake_constant_repeat: REPEAT must be in 1..65535");
        end
    endgenerate

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    load_en;
    logic                    ctrl_fire;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;

    assign ctrl_ready = !rst && (state == IDLE) && load_en;
    assign ctrl_fire  = ctrl_valid && ctrl_ready;
    assign load       = ctrl_fire || ((state == EMIT) && load_en);
    assign load_data  = (state == IDLE) ? VAL : acc;

`ifdef HANDSHAKE_CONSTANT_LAST_EN
    logic load_last;
    assign load_last = (state == IDLE) ? (REPEAT == 1) : (cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_fire && REPEAT > 1) begin
                        acc   <= VAL + STP;
                        cnt   <= CNT_W'(REPEAT - 1);
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (load_en) begin
                        acc <= acc + STP;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    handshake_constant_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .drain      (outs_ready),
        .data       (load_data),
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        .last       (load_last),
        .outs_last  (outs_last),
`endif
        .load_en    (load_en),
        .outs       (outs),
        .outs_valid (outs_valid)
    );

endmodule

// File: tb/tb_handshake_constant_repeat.sv
// Bench for handshake_constant_repeat: four configurations checked against a token-level model.
module tb_handshake_constant_repeat;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] cv;
    logic [3:0] rdy;
    logic       cr0, cr1, cr2, cr3;
    logic       ov0, ov1, ov2, ov3;
    logic [31:0] o0, o1, o3;
    logic [7:0]  o2;
`ifdef HANDSHAKE_CONSTANT_LAST_EN
    logic       ol0, ol1, ol2, ol3;
`endif

    localparam logic [31:0] PV [4] = '{32'hFFFFFFFD, 32'd10, 32'hFE, 32'd0};
    localparam logic [31:0] PS [4] = '{32'd0, 32'd3, 32'd1, 32'd3};
    localparam int          PR [4] = '{1, 4, 4, 3};
    localparam logic [31:0] PM [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFFFF};

    localparam logic [31:0] SEQ1 [8] = '{32'd10, 32'd13, 32'd16, 32'd19, 32'd0, 32'd0, 32'd0, 32'd0};
    localparam logic [31:0] SEQ2 [8] = '{32'hFE, 32'hFF, 32'h00, 32'h01, 32'd0, 32'd0, 32'd0, 32'd0};
    localparam logic [31:0] SEQ3 [8] = '{32'd0, 32'd3, 32'd6, 32'd0, 32'd3, 32'd6, 32'd0, 32'd0};

    handshake_constant_repeat u0 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[0]), .ctrl_ready(cr0),
        .outs(o0), .outs_valid(ov0),
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        .outs_last(ol0),
`endif
        .outs_ready(rdy[0])
    );

    handshake_constant_repeat #(
        .DATA_WIDTH(32), .VALUE(32'd10), .REPEAT(4), .STEP(32'd3)
    ) u1 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[1]), .ctrl_ready(cr1),
        .outs(o1), .outs_valid(ov1),
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        .outs_last(ol1),
`endif
        .outs_ready(rdy[1])
    );

    handshake_constant_repeat #(
        .DATA_WIDTH(8), .VALUE(32'hFE), .REPEAT(4), .STEP(32'd1)
    ) u2 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[2]), .ctrl_ready(cr2),
        .outs(o2), .outs_valid(ov2),
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        .outs_last(ol2),
`endif
        .outs_ready(rdy[2])
    );

    handshake_constant_repeat #(
        .DATA_WIDTH(32), .VALUE(32'd0), .REPEAT(3), .STEP(32'd3)
    ) u3 (
        .clk(clk), .rst(rst), .ctrl_valid(cv[3]), .ctrl_ready(cr3),
        .outs(o3), .outs_valid(ov3),
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        .outs_last(ol3),
`endif
        .outs_ready(rdy[3])
    );

    // Token-level model: what each output slot should hold right now.
    logic        mv   [4];
    logic [31:0] md   [4];
    logic        ml   [4];
    int          left [4];
    int          kk   [4];

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    logic [31:0] dq [4][$];
    int          fire3 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [3:0]  s_ov;
        logic [3:0]  s_cr;
        logic [31:0] s_o [4];
        logic        free;
        logic        cr_exp;
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        logic [3:0]  s_ol;
`endif
        #2;
        s_ov = {ov3, ov2, ov1, ov0};
        s_cr = {cr3, cr2, cr1, cr0};
        s_o[0] = o0;
        s_o[1] = o1;
        s_o[2] = {24'h0, o2};
        s_o[3] = o3;
`ifdef HANDSHAKE_CONSTANT_LAST_EN
        s_ol = {ol3, ol2, ol1, ol0};
`endif
        for (int i = 0; i < 4; i++) begin
            free   = !mv[i] || rdy[i];
            cr_exp = !rst && (left[i] == 0) && free;
            check($sformatf("u%0d outs_valid c%0d", i, cyc), 32'(s_ov[i]), 32'(mv[i]));
            check($sformatf("u%0d outs c%0d", i, cyc), s_o[i], md[i]);
            check($sformatf("u%0d ctrl_ready c%0d", i, cyc), 32'(s_cr[i]), 32'(cr_exp));
`ifdef HANDSHAKE_CONSTANT_LAST_EN
            check($sformatf("u%0d outs_last c%0d", i, cyc), 32'(s_ol[i]), 32'(ml[i]));
`endif
            if (!rst && s_ov[i] && rdy[i]) dq[i].push_back(s_o[i]);
            if (i == 3 && cv[3] && s_cr[3]) fire3.push_back(cyc);

            if (rst) begin
                mv[i] = 1'b0; md[i] = '0; ml[i] = 1'b0; left[i] = 0; kk[i] = 0;
            end else if (cv[i] && cr_exp) begin
                md[i] = PV[i] & PM[i]; ml[i] = (PR[i] == 1); mv[i] = 1'b1;
                kk[i] = 1; left[i] = PR[i] - 1;
            end else if (left[i] > 0 && free) begin
                md[i] = (PV[i] + 32'(kk[i]) * PS[i]) & PM[i];
                ml[i] = (left[i] == 1); mv[i] = 1'b1;
                kk[i]++; left[i]--;
            end else if (rdy[i]) begin
                mv[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_seq(input int i, input logic [31:0] e [8], input int n);
        check($sformatf("u%0d token count", i), 32'(dq[i].size()), 32'(n));
        for (int j = 0; j < n && j < dq[i].size(); j++)
            check($sformatf("u%0d token %0d", i, j), dq[i][j], e[j]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; md[i] = '0; ml[i] = 1'b0; left[i] = 0; kk[i] = 0;
        end
        rst = 1'b1;
        cv  = 4'hF;
        rdy = 4'h0;
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // Defaults run continuously; single pulses on u1 and u2.
        rst = 1'b0;
        rdy = 4'hF;
        cv  = 4'b0011;
        cycle();
        cv[1] = 1'b0;
        cv[2] = 1'b1;
        cycle();
        cv[2] = 1'b0;
        repeat (6) cycle();
        expect_seq(1, SEQ1, 4);
        expect_seq(2, SEQ2, 4);
        check("u0 tokens delivered", 32'(dq[0].size() >= 7), 32'd1);
        foreach (dq[0][j]) check($sformatf("u0 token %0d", j), dq[0][j], 32'hFFFFFFFD);

        // Stalls on u1 with ready pattern 1,0,0,1.
        dq[1].delete();
        cv[1] = 1'b1;
        cycle();
        cv[1] = 1'b0;
        for (int j = 0; j < 16; j++) begin
            rdy[1] = (j % 4 == 0 || j % 4 == 3);
            cycle();
        end
        rdy[1] = 1'b1;
        repeat (2) cycle();
        expect_seq(1, SEQ1, 4);

        // Back-to-back bursts on u3.
        dq[3].delete();
        fire3.delete();
        cv[3] = 1'b1;
        guard = 0;
        while (fire3.size() < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        cv[3] = 1'b0;
        repeat (6) cycle();
        expect_seq(3, SEQ3, 6);
        check("u3 ctrl accepts", 32'(fire3.size()), 32'd2);
        if (fire3.size() == 2) check("u3 ctrl spacing", 32'(fire3[1] - fire3[0]), 32'd3);

        // Reset in the middle of a u1 burst, then restart.
        dq[1].delete();
        cv[1] = 1'b1;
        cycle();
        cv[1] = 1'b0;
        guard = 0;
        while (dq[1].size() < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check("u1 post-reset tokens", 32'(dq[1].size()), 32'd2);
        dq[1].delete();
        cv[1] = 1'b1;
        cycle();
        cv[1] = 1'b0;
        repeat (6) cycle();
        expect_seq(1, SEQ1, 4);

        // Random traffic on every instance.
        for (int j = 0; j < 300; j++) begin
            cv  = 4'($urandom_range(0, 15)) | 4'b0001;
            rdy = 4'($urandom_range(0, 15));
            cycle();
        end
        cv  = 4'b0001;
        rdy = 4'hF;
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
